// File: rtl/ir_packet_tx_param.sv
// IR packet transmitter: start burst, car-select burst and one burst per command bit, each followed by a gap.
// Timing, command and repeat count are latched when a packet is accepted and stay fixed until it finishes.
module ir_packet_tx_param #(
  parameter int CMD_BITS = 4,
  parameter int LEN_W    = 8,
  parameter int DIV_W    = 12,
  parameter int RPT_W    = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SEND_PACKET,
  input  logic [CMD_BITS-1:0] COMMAND,
  input  logic [DIV_W-1:0]    HALF_PERIOD,
  input  logic [LEN_W-1:0]    LEN_START,
  input  logic [LEN_W-1:0]    LEN_CARSEL,
  input  logic [LEN_W-1:0]    LEN_GAP,
  input  logic [LEN_W-1:0]    LEN_ONE,
  input  logic [LEN_W-1:0]    LEN_ZERO,
  input  logic [RPT_W-1:0]    REPEAT,
  output logic                IR_LED,
  output logic                BUSY,
  output logic                DONE,
  output logic [2:0]          CURRENT_STATE
);

  localparam int DUR_W = LEN_W + DIV_W + 1;
  localparam int GC_W  = $clog2(CMD_BITS + 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    GAP    = 3'd2,
    CARSEL = 3'd3,
    ONE    = 3'd4,
    ZERO   = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [DUR_W-1:0]    dur_cnt, dur_load_val;
  logic [DIV_W-1:0]    div_cnt;
  logic                phase;
  logic [GC_W-1:0]     gap_cnt, bit_idx;
  logic [RPT_W-1:0]    rpt_cnt, rpt_q;
  logic [CMD_BITS-1:0] cmd_q;
  logic [DIV_W-1:0]    h_q, h_sel;
  logic [LEN_W-1:0]    ls_q, lc_q, lg_q, l1_q, l0_q, len_sel;
  logic                done_q;
  logic                burst, last, cmd_bit;
  logic                load, accept, gap_inc, gap_clr, rpt_inc, rpt_clr, done_n;

  function automatic logic [DIV_W-1:0] clamp_h(input logic [DIV_W-1:0] v);
    return (v == '0) ? DIV_W'(1) : v;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_l(input logic [LEN_W-1:0] v);
    return (v == '0) ? LEN_W'(1) : v;
  endfunction

  assign burst   = (state == START) || (state == CARSEL) || (state == ONE) || (state == ZERO);
  assign last    = (dur_cnt == '0);
  // Gap g (0-based) is followed by the car-select burst for g=0, else by bit g-1.
  assign bit_idx = gap_cnt - GC_W'(1);
  assign cmd_bit = |(cmd_q & (CMD_BITS'(1) << bit_idx));

  always_comb begin
    state_n = state;
    load    = 1'b0;
    accept  = 1'b0;
    gap_inc = 1'b0;
    gap_clr = 1'b0;
    rpt_inc = 1'b0;
    rpt_clr = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (SEND_PACKET) begin
          state_n = START;
          load    = 1'b1;
          accept  = 1'b1;
        end
      end
      START, CARSEL, ONE, ZERO: begin
        if (last) begin
          state_n = GAP;
          load    = 1'b1;
        end
      end
      GAP: begin
        if (last) begin
          if (gap_cnt == GC_W'(CMD_BITS + 1)) begin
            gap_clr = 1'b1;
            if (rpt_cnt < rpt_q) begin
              state_n = START;
              load    = 1'b1;
              rpt_inc = 1'b1;
            end else begin
              state_n = IDLE;
              rpt_clr = 1'b1;
              done_n  = 1'b1;
            end
          end else begin
            state_n = (gap_cnt == '0) ? CARSEL : (cmd_bit ? ONE : ZERO);
            load    = 1'b1;
            gap_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The length of the state being entered; on accept the registers are not loaded yet.
  always_comb begin
    len_sel = LEN_W'(1);
    case (state_n)
      START:   len_sel = accept ? clamp_l(LEN_START) : ls_q;
      GAP:     len_sel = lg_q;
      CARSEL:  len_sel = lc_q;
      ONE:     len_sel = l1_q;
      ZERO:    len_sel = l0_q;
      default: len_sel = LEN_W'(1);
    endcase
    h_sel        = accept ? clamp_h(HALF_PERIOD) : h_q;
    dur_load_val = ((DUR_W'(h_sel) * DUR_W'(len_sel)) << 1) - DUR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      dur_cnt <= '0;
      div_cnt <= '0;
      phase   <= 1'b0;
      gap_cnt <= '0;
      rpt_cnt <= '0;
      rpt_q   <= '0;
      cmd_q   <= '0;
      h_q     <= '0;
      ls_q    <= '0;
      lc_q    <= '0;
      lg_q    <= '0;
      l1_q    <= '0;
      l0_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
      if (accept) begin
        cmd_q <= COMMAND;
        h_q   <= clamp_h(HALF_PERIOD);
        ls_q  <= clamp_l(LEN_START);
        lc_q  <= clamp_l(LEN_CARSEL);
        lg_q  <= clamp_l(LEN_GAP);
        l1_q  <= clamp_l(LEN_ONE);
        l0_q  <= clamp_l(LEN_ZERO);
        rpt_q <= REPEAT;
      end
      if (load) begin
        dur_cnt <= dur_load_val;
      end else if (dur_cnt != '0) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
      end
      // Carrier restarts high on every state entry so each burst holds whole periods.
      if (load) begin
        div_cnt <= h_sel - DIV_W'(1);
        phase   <= 1'b0;
      end else if (burst) begin
        if (div_cnt == '0) begin
          div_cnt <= h_q - DIV_W'(1);
          phase   <= ~phase;
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
      end
      if (gap_clr || accept) begin
        gap_cnt <= '0;
      end else if (gap_inc) begin
        gap_cnt <= gap_cnt + GC_W'(1);
      end
      if (rpt_clr || accept) begin
        rpt_cnt <= '0;
      end else if (rpt_inc) begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end

  assign IR_LED        = burst && !phase;
  assign BUSY          = (state != IDLE);
  assign DONE          = done_q;
  assign CURRENT_STATE = state;

endmodule

// File: tb/tb_ir_packet_tx_param.sv
// Directed bench for ir_packet_tx_param: per-cycle traces are compared with a segment-based expectation.
module tb_ir_packet_tx_param;

  logic       CLK;
  logic       RESET;
  logic       SEND_PACKET;
  logic [3:0] COMMAND;
  logic [11:0] HALF_PERIOD;
  logic [7:0] LEN_START, LEN_CARSEL, LEN_GAP, LEN_ONE, LEN_ZERO;
  logic [2:0] REPEAT;
  logic       IR_LED, BUSY, DONE;
  logic [2:0] CURRENT_STATE;

  int checks;
  int failures;

  logic [2:0] exp_st [0:1023];
  logic       exp_led[0:1023];
  int         exp_n;
  logic [2:0] cap_st  [0:1023];
  logic       cap_led [0:1023];
  logic       cap_busy[0:1023];
  logic       cap_done[0:1023];

  ir_packet_tx_param dut (
    .CLK(CLK), .RESET(RESET), .SEND_PACKET(SEND_PACKET), .COMMAND(COMMAND),
    .HALF_PERIOD(HALF_PERIOD), .LEN_START(LEN_START), .LEN_CARSEL(LEN_CARSEL),
    .LEN_GAP(LEN_GAP), .LEN_ONE(LEN_ONE), .LEN_ZERO(LEN_ZERO), .REPEAT(REPEAT),
    .IR_LED(IR_LED), .BUSY(BUSY), .DONE(DONE), .CURRENT_STATE(CURRENT_STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected trace: a segment of len carrier periods lasts 2*h*len cycles; bursts are high for the first h of every 2h.
  task automatic add_seg(input logic [2:0] st, input int h, input int len);
    int l;
    l = (len == 0) ? 1 : len;
    for (int c = 0; c < 2 * h * l; c++) begin
      exp_st[exp_n]  = st;
      exp_led[exp_n] = (st != 3'd2) && (((c / h) % 2) == 0);
      exp_n++;
    end
  endtask

  task automatic build_exp(input int hp, input int ls, input int lc, input int lg,
                           input int l1, input int l0, input logic [3:0] cmd, input int reps);
    int h;
    h = (hp == 0) ? 1 : hp;
    exp_n = 0;
    for (int r = 0; r <= reps; r++) begin
      add_seg(3'd1, h, ls);
      add_seg(3'd2, h, lg);
      add_seg(3'd3, h, lc);
      add_seg(3'd2, h, lg);
      for (int b = 0; b < 4; b++) begin
        if (cmd[b]) add_seg(3'd4, h, l1);
        else        add_seg(3'd5, h, l0);
        add_seg(3'd2, h, lg);
      end
    end
  endtask

  function automatic int trace_errs(input int upto, output int first);
    int e;
    logic [2:0] es;
    logic el, eb, ed;
    e = 0;
    first = -1;
    for (int i = 0; i < upto; i++) begin
      if (i < exp_n) begin
        es = exp_st[i]; el = exp_led[i]; eb = 1'b1; ed = 1'b0;
      end else begin
        es = 3'd0; el = 1'b0; eb = 1'b0; ed = (i == exp_n);
      end
      if (cap_st[i] !== es || cap_led[i] !== el || cap_busy[i] !== eb || cap_done[i] !== ed) begin
        if (first < 0) first = i;
        e++;
      end
    end
    return e;
  endfunction

  function automatic int count_busy(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (cap_busy[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (cap_done[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic set_cfg(input logic [11:0] hp, input logic [7:0] ls, input logic [7:0] lc,
                         input logic [7:0] lg, input logic [7:0] l1, input logic [7:0] l0,
                         input logic [3:0] cmd, input logic [2:0] rpt);
    HALF_PERIOD = hp; LEN_START = ls; LEN_CARSEL = lc; LEN_GAP = lg;
    LEN_ONE = l1; LEN_ZERO = l0; COMMAND = cmd; REPEAT = rpt;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); @(posedge CLK); #1 RESET = 1'b0;
  endtask

  // Index 0 of the capture is the first cycle after the accepting edge.
  task automatic send();
    @(posedge CLK); #1 SEND_PACKET = 1'b1;
    @(posedge CLK); #1 SEND_PACKET = 1'b0;
  endtask

  task automatic capture(input int n, input int poke_at, input logic [3:0] poke_cmd, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cap_st[i]   = CURRENT_STATE;
      cap_led[i]  = IR_LED;
      cap_busy[i] = BUSY;
      cap_done[i] = DONE;
      if (i == poke_at) begin
        SEND_PACKET = 1'b1;
        COMMAND     = poke_cmd;
        LEN_START   = 8'd9;
        HALF_PERIOD = 12'd5;
      end
      if (i == poke_at + 1) SEND_PACKET = 1'b0;
      if (i == rst_at) RESET = 1'b1;
      if (i == rst_at + 1) RESET = 1'b0;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (IR_LED !== 1'b0) begin failures++; $display("FAIL reset_led cycle=%0d got=%b want=0", i, IR_LED); end
      checks++;
      if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy cycle=%0d got=%b want=0", i, BUSY); end
      checks++;
      if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done cycle=%0d got=%b want=0", i, DONE); end
      checks++;
      if (CURRENT_STATE !== 3'd0) begin failures++; $display("FAIL reset_state cycle=%0d got=%0d want=0", i, CURRENT_STATE); end
    end
    @(posedge CLK); #1 RESET = 1'b0;
  endtask

  task automatic test_single_packet();
    int e, first, hi;
    do_reset();
    set_cfg(12'd2, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 4'b1010, 3'd0);
    build_exp(2, 3, 2, 1, 2, 1, 4'b1010, 0);
    send();
    capture(72, -10, 4'b0000, -10);
    e = trace_errs(72, first);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL single_trace mismatches=%0d first_cycle=%0d want=0", e, first); end
    checks++;
    if (count_busy(72) !== 68) begin failures++; $display("FAIL single_busy_len got=%0d want=68", count_busy(72)); end
    checks++;
    if (count_done(72) !== 1 || cap_done[68] !== 1'b1) begin
      failures++; $display("FAIL single_done count=%0d at68=%b want=1/1", count_done(72), cap_done[68]);
    end
    hi = 0;
    for (int i = 0; i < 12; i++) if (cap_st[i] === 3'd1 && cap_led[i] === 1'b1) hi++;
    checks++;
    if (hi !== 6) begin failures++; $display("FAIL single_start_high got=%0d want=6", hi); end
  endtask

  task automatic test_carrier_phase();
    int e, first, rises;
    do_reset();
    set_cfg(12'd3, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 4'b1010, 3'd0);
    build_exp(3, 3, 2, 1, 2, 1, 4'b1010, 0);
    send();
    capture(106, -10, 4'b0000, -10);
    e = trace_errs(106, first);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL phase_trace mismatches=%0d first_cycle=%0d want=0", e, first); end
    rises = 0;
    for (int i = 0; i < 18; i++)
      if (cap_st[i] === 3'd1 && cap_led[i] === 1'b1 && (i == 0 || cap_led[i-1] === 1'b0)) rises++;
    checks++;
    if (rises !== 3) begin failures++; $display("FAIL phase_start_periods got=%0d want=3", rises); end
    checks++;
    if ({cap_st[24], cap_led[24], cap_led[25], cap_led[26], cap_led[27]} !== {3'd3, 4'b1110}) begin
      failures++;
      $display("FAIL phase_carsel_start st=%0d led=%b%b%b%b want=3 1110", cap_st[24], cap_led[24], cap_led[25], cap_led[26], cap_led[27]);
    end
    checks++;
    if (count_busy(106) !== 102) begin failures++; $display("FAIL phase_busy_len got=%0d want=102", count_busy(106)); end
  endtask

  task automatic test_repeat_ignore();
    int e, first;
    do_reset();
    set_cfg(12'd2, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 4'b1010, 3'd2);
    build_exp(2, 3, 2, 1, 2, 1, 4'b1010, 2);
    send();
    capture(210, 30, 4'b0101, -10);
    e = trace_errs(210, first);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL repeat_trace mismatches=%0d first_cycle=%0d want=0", e, first); end
    checks++;
    if (count_busy(210) !== 204) begin failures++; $display("FAIL repeat_busy_len got=%0d want=204", count_busy(210)); end
    checks++;
    if (count_done(210) !== 1) begin failures++; $display("FAIL repeat_done_count got=%0d want=1", count_done(210)); end
  endtask

  task automatic test_zero_clamps();
    int e, first;
    do_reset();
    set_cfg(12'd0, 8'd3, 8'd2, 8'd0, 8'd2, 8'd1, 4'b1010, 3'd0);
    build_exp(0, 3, 2, 0, 2, 1, 4'b1010, 0);
    send();
    capture(38, -10, 4'b0000, -10);
    e = trace_errs(38, first);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL clamp_trace mismatches=%0d first_cycle=%0d want=0", e, first); end
    checks++;
    if ({cap_st[5], cap_st[6], cap_st[7], cap_st[8]} !== {3'd1, 3'd2, 3'd2, 3'd3}) begin
      failures++;
      $display("FAIL clamp_gap_len states=%0d,%0d,%0d,%0d want=1,2,2,3", cap_st[5], cap_st[6], cap_st[7], cap_st[8]);
    end
    checks++;
    if (count_busy(38) !== 34) begin failures++; $display("FAIL clamp_busy_len got=%0d want=34", count_busy(38)); end
  endtask

  task automatic test_abort();
    int e, first;
    do_reset();
    set_cfg(12'd2, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 4'b1010, 3'd0);
    build_exp(2, 3, 2, 1, 2, 1, 4'b1010, 0);
    send();
    capture(30, -10, 4'b0000, 19);
    e = trace_errs(20, first);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL abort_prefix mismatches=%0d first_cycle=%0d want=0", e, first); end
    checks++;
    if ({cap_st[20], cap_led[20], cap_busy[20]} !== 5'b0) begin
      failures++; $display("FAIL abort_idle st=%0d led=%b busy=%b want=0 0 0", cap_st[20], cap_led[20], cap_busy[20]);
    end
    checks++;
    if (count_done(30) !== 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", count_done(30)); end
    send();
    capture(72, -10, 4'b0000, -10);
    e = trace_errs(72, first);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL abort_fresh mismatches=%0d first_cycle=%0d want=0", e, first); end
  endtask

  task automatic test_back_to_back();
    int e, first;
    do_reset();
    set_cfg(12'd2, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 4'b1010, 3'd0);
    build_exp(2, 3, 2, 1, 2, 1, 4'b1010, 0);
    send();
    capture(71, 68, 4'b1010, -10);
    e = trace_errs(69, first);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL b2b_first mismatches=%0d first_cycle=%0d want=0", e, first); end
    checks++;
    if ({cap_st[69], cap_busy[69], cap_done[69], cap_led[69]} !== {3'd1, 3'b101}) begin
      failures++;
      $display("FAIL b2b_restart st=%0d busy=%b done=%b led=%b want=1 1 0 1", cap_st[69], cap_busy[69], cap_done[69], cap_led[69]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RESET = 1'b1;
    SEND_PACKET = 1'b0;
    set_cfg(12'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 3'd0);
    test_reset();
    test_single_packet();
    test_carrier_phase();
    test_repeat_ignore();
    test_zero_clamps();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
